// File: rtl/opc5ls_memctl.sv
// OPC5LS memory controller: splits each 16-bit CPU access into two little-endian
// byte cycles on an 8-bit async SRAM and stalls the CPU through cpu_clken.
module opc5ls_memctl #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_dout,
    input  logic        cpu_rnw,
    input  logic        cpu_mreq_b,
    output logic [15:0] cpu_din,
    output logic        cpu_clken,
    output logic [16:0] ram_addr,
    output logic [7:0]  ram_data_out,
    input  logic [7:0]  ram_data_in,
    output logic        ram_data_oe,
    output logic        ram_ce_b,
    output logic        ram_oe_b,
    output logic        ram_we_b
);

    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] STROBE_END = CNT_W'(WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WAIT_STATES + 2);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rnw_q, rnw_d;
    logic [7:0]       lo_q, lo_d;
    logic [7:0]       hi_q, hi_d;
    logic [15:0]      din_q, din_d;
    logic [16:0]      addr_q, addr_d;
    logic [7:0]       dout_q, dout_d;
    logic             ce_b_q, ce_b_d;
    logic             oe_b_q, oe_b_d;
    logic             we_b_q, we_b_d;
    logic             data_oe_q, data_oe_d;
    logic             in_phase;
    logic             strobe;

    // Next state, byte capture, and registered SRAM controls derived from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        din_d   = din_q;
        addr_d  = addr_q;
        dout_d  = dout_q;

        case (state_q)
            IDLE: begin
                if (!cpu_mreq_b) begin
                    state_d = LO;
                    cnt_d   = '0;
                    rnw_d   = cpu_rnw;
                end
            end
            LO, HI: begin
                if (rnw_q && (cnt_q == STROBE_END)) begin
                    if (state_q == LO) lo_d = ram_data_in;
                    else               hi_d = ram_data_in;
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = (state_q == LO) ? HI : DONE;
                    if ((state_q == HI) && rnw_q) din_d = {hi_q, lo_q};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are computed for the cycle the FSM enters next
        in_phase  = (state_d == LO) || (state_d == HI);
        strobe    = in_phase && (cnt_d >= CNT_W'(1)) && (cnt_d <= STROBE_END);
        ce_b_d    = !in_phase;
        oe_b_d    = !(strobe && rnw_d);
        we_b_d    = !(strobe && !rnw_d);
        data_oe_d = in_phase && !rnw_d;
        if (in_phase) begin
            addr_d = {cpu_address, (state_d == HI)};
            dout_d = (state_d == HI) ? cpu_dout[15:8] : cpu_dout[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rnw_q     <= 1'b1;
            lo_q      <= '0;
            hi_q      <= '0;
            din_q     <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            ce_b_q    <= 1'b1;
            oe_b_q    <= 1'b1;
            we_b_q    <= 1'b1;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rnw_q     <= rnw_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            din_q     <= din_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            ce_b_q    <= ce_b_d;
            oe_b_q    <= oe_b_d;
            we_b_q    <= we_b_d;
            data_oe_q <= data_oe_d;
        end
    end

    // Clock enable stays combinational so the CPU can run during reset and see the DONE pulse
    assign cpu_clken    = !reset_b || ((state_q == IDLE) && cpu_mreq_b) || (state_q == DONE);
    assign cpu_din      = din_q;
    assign ram_addr     = addr_q;
    assign ram_data_out = dout_q;
    assign ram_data_oe  = data_oe_q;
    assign ram_ce_b     = ce_b_q;
    assign ram_oe_b     = oe_b_q;
    assign ram_we_b     = we_b_q;

endmodule

// File: tb/tb_opc5ls_memctl.sv
// Directed bench for opc5ls_memctl: SRAM models, strobe monitor and a read-data scoreboard.
module tb_opc5ls_memctl;

    logic        clk = 1'b0;
    logic        reset_b;
    always #5 clk = ~clk;

    // Main instance (WAIT_STATES=1)
    logic [15:0] cpu_address, cpu_dout, cpu_din;
    logic        cpu_rnw, cpu_mreq_b, cpu_clken;
    logic [16:0] ram_addr;
    logic [7:0]  ram_data_out, ram_data_in;
    logic        ram_data_oe, ram_ce_b, ram_oe_b, ram_we_b;
    logic [7:0]  mem [0:131071];

    // Zero-wait-state instance
    logic [15:0] a0, d0, din0;
    logic        r0, m0, clken0;
    logic [16:0] raddr0;
    logic [7:0]  rdo0, rdi0;
    logic        doe0, ce0, oe0, we0;
    logic [7:0]  mem0 [0:131071];

    opc5ls_memctl #(.WAIT_STATES(1)) u_dut (
        .clk(clk), .reset_b(reset_b),
        .cpu_address(cpu_address), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw),
        .cpu_mreq_b(cpu_mreq_b), .cpu_din(cpu_din), .cpu_clken(cpu_clken),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
        .ram_data_oe(ram_data_oe), .ram_ce_b(ram_ce_b), .ram_oe_b(ram_oe_b),
        .ram_we_b(ram_we_b)
    );

    opc5ls_memctl #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset_b(reset_b),
        .cpu_address(a0), .cpu_dout(d0), .cpu_rnw(r0),
        .cpu_mreq_b(m0), .cpu_din(din0), .cpu_clken(clken0),
        .ram_addr(raddr0), .ram_data_out(rdo0), .ram_data_in(rdi0),
        .ram_data_oe(doe0), .ram_ce_b(ce0), .ram_oe_b(oe0),
        .ram_we_b(we0)
    );

    // Async SRAM models: read when ce/oe low, write committed on clock edges with we low
    assign ram_data_in = (!ram_ce_b && !ram_oe_b) ? mem[ram_addr] : 8'hxx;
    assign rdi0        = (!ce0 && !oe0) ? mem0[raddr0] : 8'hxx;
    always @(posedge clk) if (reset_b && !ram_ce_b && !ram_we_b && ram_data_oe) mem[ram_addr] <= ram_data_out;
    always @(posedge clk) if (reset_b && !ce0 && !we0 && doe0) mem0[raddr0] <= rdo0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] sb [$];
    logic [15:0] last_din;

    // Per-byte-phase strobe monitor on the main instance
    logic        mon_en = 1'b0;
    int          we_lo [2];
    int          oe_lo [2];
    int          doe_hi [2];
    int          overlap;
    logic [16:0] oe_addr [2];
    always @(negedge clk) begin
        if (mon_en) begin
            if (!ram_we_b)              we_lo[ram_addr[0]]++;
            if (!ram_oe_b)              begin oe_lo[ram_addr[0]]++; oe_addr[ram_addr[0]] = ram_addr; end
            if (ram_data_oe)            doe_hi[ram_addr[0]]++;
            if (!ram_we_b && !ram_oe_b) overlap++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 2; i++) begin
            we_lo[i] = 0; oe_lo[i] = 0; doe_hi[i] = 0; oe_addr[i] = '0;
        end
        overlap = 0;
    endtask

    // Issue one access from a negedge; cyc = negedge samples until clken rises
    task automatic access(input string tag, input logic [15:0] a, input logic [15:0] d,
                          input logic r, input logic chained, output int cyc);
        logic got;
        logic [15:0] exp_din;
        sb.push_back(r ? {mem[{a, 1'b1}], mem[{a, 1'b0}]} : last_din);
        cpu_address = a; cpu_dout = d; cpu_rnw = r; cpu_mreq_b = 1'b0;
        clear_mon();
        mon_en = 1'b1;
        if (!chained) begin
            #1;
            check({tag, "_idle_clken"}, cpu_clken, 1'b0);
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (cpu_clken) got = 1'b1;
        end
        mon_en = 1'b0;
        cpu_mreq_b = 1'b1;
        check({tag, "_done"}, got, 1'b1);
        exp_din = sb.pop_front();
        check({tag, "_din"}, cpu_din, exp_din);
        last_din = exp_din;
        check({tag, "_overlap"}, overlap, 0);
    endtask

    initial begin
        int cyc;
        logic got;
        int oe0_cnt [2];

        reset_b = 1'b0;
        cpu_address = '0; cpu_dout = '0; cpu_rnw = 1'b1; cpu_mreq_b = 1'b1;
        a0 = '0; d0 = '0; r0 = 1'b1; m0 = 1'b1;
        last_din = '0;
        mem[17'h00008] = 8'h34;  mem[17'h00009] = 8'h12;
        mem[17'h1FFFE] = 8'h00;  mem[17'h1FFFF] = 8'h00;
        mem[17'h00020] = 8'hCD;  mem[17'h00021] = 8'hAB;
        mem[17'h00022] = 8'h00;  mem[17'h00023] = 8'h00;
        mem[17'h00040] = 8'h11;  mem[17'h00041] = 8'h22;
        mem0[17'h000C4] = 8'h78; mem0[17'h000C5] = 8'h56;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_clken", cpu_clken, 1'b1);
        check("rst_ctrl", {ram_ce_b, ram_oe_b, ram_we_b, ram_data_oe}, 4'b1110);
        check("rst_addr", ram_addr, 17'h0);
        check("rst_dout", ram_data_out, 8'h0);
        check("rst_din", cpu_din, 16'h0);
        reset_b = 1'b1;

        // Passthrough with no memory request
        clear_mon();
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("pass_clken", cpu_clken, 1'b1);
            check("pass_ce", ram_ce_b, 1'b1);
        end
        mon_en = 1'b0;
        check("pass_strobes", we_lo[0] + we_lo[1] + oe_lo[0] + oe_lo[1] + doe_hi[0] + doe_hi[1], 0);

        // Read 0x0004 -> 0x1234
        @(negedge clk);
        access("rd", 16'h0004, 16'h0000, 1'b1, 1'b0, cyc);
        check("rd_latency", cyc + 1, 10);
        check("rd_oe_lo", oe_lo[0], 2);
        check("rd_oe_hi", oe_lo[1], 2);
        check("rd_addr_lo", oe_addr[0], 17'h00008);
        check("rd_addr_hi", oe_addr[1], 17'h00009);
        check("rd_no_we", we_lo[0] + we_lo[1], 0);

        // Write 0xBEEF to top word
        repeat (2) @(negedge clk);
        access("wr", 16'hFFFF, 16'hBEEF, 1'b0, 1'b0, cyc);
        check("wr_latency", cyc + 1, 10);
        check("wr_we_lo", we_lo[0], 2);
        check("wr_we_hi", we_lo[1], 2);
        check("wr_doe_lo", doe_hi[0], 4);
        check("wr_doe_hi", doe_hi[1], 4);
        check("wr_mem_lo", mem[17'h1FFFE], 8'hEF);
        check("wr_mem_hi", mem[17'h1FFFF], 8'hBE);

        // Back-to-back read then write; chained access sees exactly one IDLE cycle
        repeat (2) @(negedge clk);
        access("b2b_rd", 16'h0010, 16'h0000, 1'b1, 1'b0, cyc);
        check("b2b_rd_latency", cyc + 1, 10);
        access("b2b_wr", 16'h0011, 16'h5A5A, 1'b0, 1'b1, cyc);
        check("b2b_wr_cycles", cyc, 10);
        check("b2b_mem_lo", mem[17'h00022], 8'h5A);
        check("b2b_mem_hi", mem[17'h00023], 8'h5A);

        // Zero wait states on the second instance
        @(negedge clk);
        sb.push_back({mem0[17'h000C5], mem0[17'h000C4]});
        a0 = 16'h0062; r0 = 1'b1; m0 = 1'b0;
        oe0_cnt[0] = 0; oe0_cnt[1] = 0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (!oe0) oe0_cnt[raddr0[0]]++;
            if (clken0) got = 1'b1;
        end
        m0 = 1'b1;
        check("ws0_done", got, 1'b1);
        check("ws0_latency", cyc + 1, 8);
        check("ws0_din", din0, sb.pop_front());
        check("ws0_oe_lo", oe0_cnt[0], 1);
        check("ws0_oe_hi", oe0_cnt[1], 1);

        // Reset asserted during the high-byte write strobe
        repeat (2) @(negedge clk);
        cpu_address = 16'h0020; cpu_dout = 16'hA55A; cpu_rnw = 1'b0; cpu_mreq_b = 1'b0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 32) begin
            @(negedge clk);
            cyc++;
            if (!ram_we_b && ram_addr[0]) got = 1'b1;
        end
        check("mr_hi_strobe_seen", got, 1'b1);
        reset_b = 1'b0;
        #1;
        check("mr_we", ram_we_b, 1'b1);
        check("mr_ce", ram_ce_b, 1'b1);
        check("mr_oe", ram_oe_b, 1'b1);
        check("mr_clken", cpu_clken, 1'b1);
        check("mr_din", cpu_din, 16'h0);
        cpu_mreq_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b1;
        last_din = '0;
        @(negedge clk);
        check("mr_idle_clken", cpu_clken, 1'b1);
        check("mr_idle_ce", ram_ce_b, 1'b1);
        check("mr_mem_lo", mem[17'h00040], 8'h5A);
        check("mr_mem_hi", mem[17'h00041], 8'h22);

        // Controller still works after the aborted write
        access("post_rd", 16'h0004, 16'h0000, 1'b1, 1'b0, cyc);
        check("post_rd_latency", cyc + 1, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
